conv_41: RTL and testbench
==========================

Name: conv_41

Overview:
- Parallel-to-serial converter: the transmit-side counterpart of the 1-to-4 splitter in the multiplier datapath.
- Accepts one group of four lanes (din1..din4) per handshake and emits them on a single output, one lane per beat, in order din1, din2, din3, din4.
- Sits between the partial-product/lane stage and any single-lane consumer. Supports downstream backpressure and back-to-back groups with no idle cycle.

Parameters:
- W, 1, width in bits of each lane and of dout.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- din1  input  W  lane 1, first beat out.
- din2  input  W  lane 2, second beat out.
- din3  input  W  lane 3, third beat out.
- din4  input  W  lane 4, fourth beat out.
- din_valid  input  1  din1..din4 hold a valid group.
- din_ready  output  1  converter accepts a group this cycle.
- dout  output  W  current serial beat.
- dout_valid  output  1  dout holds a valid beat.
- dout_ready  input  1  consumer accepts dout this cycle.
- dout_first  output  1  current beat is lane 1 of its group.
- dout_last  output  1  current beat is lane 4 of its group.

Behaviour:
- Reset (rst=1 at a clock edge) clears the block on that edge:
  - state=IDLE, beat counter=0, holding register=0.
  - dout=0, dout_valid=0, dout_first=0, dout_last=0.
  - rst overrides every other input, including mid-group; a partially sent group is discarded, not resumed.
- States:
  - IDLE: dout_valid=0.
  - SEND: dout_valid=1; 2-bit beat counter cnt selects the lane, 0..3.
- Input acceptance: accept = din_valid & din_ready.
  - din_ready = (state==IDLE) | (state==SEND & cnt==3 & dout_ready).
  - din_ready is combinational from state, cnt and dout_ready only; it does not depend on din_valid.
- On accept, din1..din4 are captured into a 4W holding register. Next state is SEND with cnt=0.
  - Latency: the group is accepted at edge N and lane 1 appears on dout from edge N, i.e. in the cycle after acceptance.
- Output beat: dout_fire = dout_valid & dout_ready.
  - SEND and dout_fire and cnt<3: cnt increments.
  - SEND and dout_fire and cnt==3:
    - accept also true: reload the holding register, cnt=0, stay in SEND (back-to-back, no bubble).
    - otherwise: go to IDLE.
  - SEND and not dout_ready: hold. dout, cnt, dout_first and dout_last stay stable, and din_ready=0.
- Outputs are registered or decoded from registered state only; no combinational path from din* to dout.
  - dout = lane[cnt] of the holding register in SEND; 0 in IDLE.
  - dout_first = SEND & cnt==0.
  - dout_last = SEND & cnt==3.
- Holding register and din* are ignored unless accept is true.
- Throughput: one group per 4 cycles when dout_ready=1 continuously and din_valid=1.
- No arithmetic; lanes pass bit-exact at width W.

Test Plan:
- Reset mid-group:
  - W=4. Load 1,2,3,4 and send two beats, then assert rst for 1 cycle.
  - Required: next cycle dout_valid=0, dout=0, din_ready=1. A following group 5,6,7,8 emits 5,6,7,8 with first/last on beats 1/4.
- Single group, no stall:
  - W=4. din1..4=A,B,C,D, din_valid one cycle, dout_ready=1.
  - Required: dout=A,B,C,D on four consecutive cycles starting the cycle after accept; dout_first only on A, dout_last only on D; dout_valid=0 afterwards.
- Back-to-back:
  - din_valid held high with groups (1,2,3,4) then (5,6,7,8), dout_ready=1.
  - Required: dout 1..8 on 8 consecutive cycles with no dout_valid gap; din_ready high only on the idle-accept cycle and the cnt==3 cycle.
- Backpressure:
  - Group 9,A,B,C; drop dout_ready for 3 cycles while dout=A.
  - Required: dout stays A with dout_valid=1 and din_ready=0; on release, B then C follow.
- Stall on last beat:
  - dout_ready=0 while dout_last=1 and din_valid=1.
  - Required: din_ready=0 and the new group is not captured; when dout_ready=1, the new group is accepted on that same edge.
- Width W=1:
  - Groups 1,0,1,1 then 0,1,0,0.
  - Required: serial stream 1,0,1,1,0,1,0,0 with correct first/last flags.

Source files
------------

// File: rtl/conv_41.sv
// Parallel-to-serial converter: takes one four-lane group per handshake and
// replays it on a single lane, din1 first, with first/last beat markers.
module conv_41 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din1,
    input  logic [W-1:0] din2,
    input  logic [W-1:0] din3,
    input  logic [W-1:0] din4,
    input  logic         din_valid,
    output logic         din_ready,
    output logic [W-1:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         dout_first,
    output logic         dout_last
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state, state_nx;
    logic [1:0]          cnt, cnt_nx;
    logic [3:0][W-1:0]   hold;
    logic                accept, dout_fire;

    // din_ready must not look at din_valid, so upstream may wait on it freely
    assign din_ready  = (state == IDLE) | ((state == SEND) & (cnt == 2'd3) & dout_ready);
    assign accept     = din_valid & din_ready;
    assign dout_valid = (state == SEND);
    assign dout_fire  = dout_valid & dout_ready;
    assign dout       = (state == SEND) ? hold[cnt] : '0;
    assign dout_first = (state == SEND) & (cnt == 2'd0);
    assign dout_last  = (state == SEND) & (cnt == 2'd3);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = SEND;
                    cnt_nx   = 2'd0;
                end
            end
            SEND: begin
                if (dout_fire) begin
                    if (cnt != 2'd3) begin
                        cnt_nx = cnt + 2'd1;
                    end else if (accept) begin
                        cnt_nx = 2'd0;
                    end else begin
                        state_nx = IDLE;
                        cnt_nx   = 2'd0;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
            hold  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) hold <= {din4, din3, din2, din1};
        end
    end

endmodule

// File: tb/tb_conv_41.sv
// Directed bench for conv_41 at W=4 and W=1; expected beats are queued when a
// group is driven and compared as the converter emits them.
module tb_conv_41;

    typedef struct {
        logic [3:0] d;
        logic       f;
        logic       l;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [3:0] a1 = '0, a2 = '0, a3 = '0, a4 = '0;
    logic       v4 = 1'b0, r4 = 1'b0;
    logic       rdy4, vld4, first4, last4;
    logic [3:0] dout4;

    logic       b1 = '0, b2 = '0, b3 = '0, b4 = '0;
    logic       v1 = 1'b0, r1 = 1'b0;
    logic       rdy1, vld1, first1, last1;
    logic       dout1;

    beat_t q4[$];
    beat_t q1[$];
    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    conv_41 #(.W(4)) dut4 (
        .clk(clk), .rst(rst),
        .din1(a1), .din2(a2), .din3(a3), .din4(a4),
        .din_valid(v4), .din_ready(rdy4),
        .dout(dout4), .dout_valid(vld4), .dout_ready(r4),
        .dout_first(first4), .dout_last(last4)
    );

    conv_41 #(.W(1)) dut1 (
        .clk(clk), .rst(rst),
        .din1(b1), .din2(b2), .din3(b3), .din4(b4),
        .din_valid(v1), .din_ready(rdy1),
        .dout(dout1), .dout_valid(vld1), .dout_ready(r1),
        .dout_first(first1), .dout_last(last1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push4(input logic [3:0] d1, d2, d3, d4);
        q4.push_back('{d1, 1'b1, 1'b0});
        q4.push_back('{d2, 1'b0, 1'b0});
        q4.push_back('{d3, 1'b0, 1'b0});
        q4.push_back('{d4, 1'b0, 1'b1});
    endtask

    task automatic push1(input logic d1, d2, d3, d4);
        q1.push_back('{{3'b0, d1}, 1'b1, 1'b0});
        q1.push_back('{{3'b0, d2}, 1'b0, 1'b0});
        q1.push_back('{{3'b0, d3}, 1'b0, 1'b0});
        q1.push_back('{{3'b0, d4}, 1'b0, 1'b1});
    endtask

    // One cycle on the W=4 instance: drive, check handshake mid-cycle, clock.
    task automatic step4(input logic v, input logic r, input logic er, input logic ev);
        v4 = v;
        r4 = r;
        @(negedge clk);
        chk("w4 din_ready", rdy4, er);
        chk("w4 dout_valid", vld4, ev);
        if (!r && ev && q4.size() != 0) begin
            chk("w4 stall dout", dout4, q4[0].d);
            chk("w4 stall first", first4, q4[0].f);
            chk("w4 stall last", last4, q4[0].l);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input logic v, input logic r, input logic er, input logic ev);
        v1 = v;
        r1 = r;
        @(negedge clk);
        chk("w1 din_ready", rdy1, er);
        chk("w1 dout_valid", vld1, ev);
        @(posedge clk);
        #1;
    endtask

    task automatic send_group4(input logic [3:0] d1, d2, d3, d4);
        a1 = d1; a2 = d2; a3 = d3; a4 = d4;
        push4(d1, d2, d3, d4);
        step4(1, 1, 1, 0);
        repeat (3) step4(0, 1, 0, 1);
        step4(0, 1, 1, 1);
        step4(0, 1, 1, 0);
    endtask

    always @(negedge clk) begin
        if (vld4 && r4) begin
            chk("w4 beat expected", (q4.size() != 0), 1);
            if (q4.size() != 0) begin
                beat_t e;
                e = q4.pop_front();
                chk("w4 dout", dout4, e.d);
                chk("w4 first", first4, e.f);
                chk("w4 last", last4, e.l);
            end
        end
        if (vld1 && r1) begin
            chk("w1 beat expected", (q1.size() != 0), 1);
            if (q1.size() != 0) begin
                beat_t e;
                e = q1.pop_front();
                chk("w1 dout", dout1, e.d[0]);
                chk("w1 first", first1, e.f);
                chk("w1 last", last1, e.l);
            end
        end
    end

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst dout_valid", vld4, 0);
        chk("rst dout", dout4, 0);
        chk("rst first", first4, 0);
        chk("rst last", last4, 0);
        chk("rst din_ready", rdy4, 1);
        chk("rst w1 dout_valid", vld1, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // reset mid-group: two beats out, then reset discards the rest
        a1 = 4'd1; a2 = 4'd2; a3 = 4'd3; a4 = 4'd4;
        push4(4'd1, 4'd2, 4'd3, 4'd4);
        step4(1, 1, 1, 0);
        step4(0, 1, 0, 1);
        step4(0, 1, 0, 1);
        rst = 1'b1;
        step4(0, 0, 0, 1);
        rst = 1'b0;
        q4.delete();
        @(negedge clk);
        chk("post-rst dout_valid", vld4, 0);
        chk("post-rst dout", dout4, 0);
        chk("post-rst din_ready", rdy4, 1);
        @(posedge clk);
        #1;
        send_group4(4'd5, 4'd6, 4'd7, 4'd8);

        // single group, no stall
        send_group4(4'hA, 4'hB, 4'hC, 4'hD);

        // back-to-back groups with din_valid held high
        a1 = 4'd1; a2 = 4'd2; a3 = 4'd3; a4 = 4'd4;
        push4(4'd1, 4'd2, 4'd3, 4'd4);
        step4(1, 1, 1, 0);
        repeat (3) step4(1, 1, 0, 1);
        a1 = 4'd5; a2 = 4'd6; a3 = 4'd7; a4 = 4'd8;
        push4(4'd5, 4'd6, 4'd7, 4'd8);
        step4(1, 1, 1, 1);
        repeat (3) step4(0, 1, 0, 1);
        step4(0, 1, 1, 1);
        step4(0, 1, 1, 0);

        // backpressure while dout=A
        a1 = 4'h9; a2 = 4'hA; a3 = 4'hB; a4 = 4'hC;
        push4(4'h9, 4'hA, 4'hB, 4'hC);
        step4(1, 1, 1, 0);
        step4(0, 1, 0, 1);
        repeat (3) step4(0, 0, 0, 1);
        step4(0, 1, 0, 1);
        step4(0, 1, 0, 1);
        step4(0, 1, 1, 1);
        step4(0, 1, 1, 0);

        // stall on the last beat with a new group waiting
        a1 = 4'h3; a2 = 4'h5; a3 = 4'h7; a4 = 4'h9;
        push4(4'h3, 4'h5, 4'h7, 4'h9);
        step4(1, 1, 1, 0);
        repeat (3) step4(0, 1, 0, 1);
        a1 = 4'hF; a2 = 4'hF; a3 = 4'hF; a4 = 4'hF;
        step4(1, 0, 0, 1);
        a1 = 4'hE; a2 = 4'hD; a3 = 4'hC; a4 = 4'hB;
        step4(1, 0, 0, 1);
        push4(4'hE, 4'hD, 4'hC, 4'hB);
        step4(1, 1, 1, 1);
        repeat (3) step4(0, 1, 0, 1);
        step4(0, 1, 1, 1);
        step4(0, 1, 1, 0);

        // W=1: two back-to-back groups
        b1 = 1'b1; b2 = 1'b0; b3 = 1'b1; b4 = 1'b1;
        push1(1'b1, 1'b0, 1'b1, 1'b1);
        step1(1, 1, 1, 0);
        repeat (3) step1(1, 1, 0, 1);
        b1 = 1'b0; b2 = 1'b1; b3 = 1'b0; b4 = 1'b0;
        push1(1'b0, 1'b1, 1'b0, 1'b0);
        step1(1, 1, 1, 1);
        repeat (3) step1(0, 1, 0, 1);
        step1(0, 1, 1, 1);
        step1(0, 1, 1, 0);

        chk("w4 beats left", q4.size(), 0);
        chk("w1 beats left", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
